// File: rtl/registered_mux_scanner_if.sv
// Bus bundle for registered_mux_scanner: channel data, select/scan/capture
// controls in, gated output and scan status out.
interface registered_mux_scanner_if #(
    parameter int WIDTH  = 2,
    parameter int INPUTS = 4
);
    localparam int SEL_W = $clog2(INPUTS);

    logic [INPUTS*WIDTH-1:0] data_i;
    logic [SEL_W-1:0]        sel_i;
    logic                    sel_load_i;
    logic                    scan_en_i;
    logic [SEL_W-1:0]        scan_last_i;
    logic                    capture_i;
    logic [WIDTH-1:0]        enable_n_i;
    logic [WIDTH-1:0]        out_o;
    logic [SEL_W-1:0]        cur_sel_o;
    logic                    wrap_o;
    logic                    out_valid_o;

    modport master (
        output data_i, sel_i, sel_load_i, scan_en_i, scan_last_i, capture_i, enable_n_i,
        input  out_o, cur_sel_o, wrap_o, out_valid_o
    );

    modport slave (
        input  data_i, sel_i, sel_load_i, scan_en_i, scan_last_i, capture_i, enable_n_i,
        output out_o, cur_sel_o, wrap_o, out_valid_o
    );
endinterface

// File: rtl/registered_mux_scanner.sv
// INPUTS-to-1 selector with a registered select, auto-scan over a programmable
// range, a registered capture output and per-bit active-low output gating.
module registered_mux_scanner #(
    parameter int WIDTH  = 2,
    parameter int INPUTS = 4
) (
    input logic                    clk_i,
    input logic                    rst_i,
    registered_mux_scanner_if.slave bus
);
    localparam int SEL_W = $clog2(INPUTS);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(INPUTS - 1);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wrap_q, wrap_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] chan [INPUTS];
    logic [WIDTH-1:0] mux_out;

    always_comb begin
        for (int i = 0; i < INPUTS; i++) begin
            chan[i] = bus.data_i[i*WIDTH +: WIDTH];
        end
    end

    assign mux_out = chan[sel_q];

    // A start above scan_last still terminates at the top channel.
    always_comb begin
        sel_d  = sel_q;
        wrap_d = 1'b0;
        if (bus.sel_load_i) begin
            sel_d = bus.sel_i;
        end else if (bus.scan_en_i) begin
            if (sel_q == bus.scan_last_i || sel_q == SEL_MAX) begin
                sel_d  = '0;
                wrap_d = 1'b1;
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (bus.capture_i) begin
            data_d  = mux_out;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q   <= '0;
            data_q  <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            data_q  <= data_d;
            wrap_q  <= wrap_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_o       = data_q & ~bus.enable_n_i;
    assign bus.cur_sel_o   = sel_q;
    assign bus.wrap_o      = wrap_q;
    assign bus.out_valid_o = valid_q;
endmodule

// File: tb/tb_registered_mux_scanner.sv
// Directed bench for registered_mux_scanner: expected outputs are queued as
// stimulus is driven and popped for comparison once the DUT has responded.
module tb_registered_mux_scanner;
    localparam int WIDTH  = 2;
    localparam int INPUTS = 4;

    typedef struct {
        string      tag;
        logic [1:0] out;
        logic [1:0] cur;
        logic       wrap;
        logic       valid;
    } exp_t;

    logic clk;
    logic rst;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb [$];

    registered_mux_scanner_if #(.WIDTH(WIDTH), .INPUTS(INPUTS)) bus ();

    registered_mux_scanner #(.WIDTH(WIDTH), .INPUTS(INPUTS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string tag, input logic [1:0] o, input logic [1:0] c,
                              input logic w, input logic v);
        exp_t e;
        e.tag = tag; e.out = o; e.cur = c; e.wrap = w; e.valid = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        compared++;
        assert (sb.size() != 0) else begin
            mismatched++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (bus.out_o === e.out) else begin
                mismatched++;
                $error("FAIL %s out: observed %b expected %b", e.tag, bus.out_o, e.out);
            end
            compared++;
            assert (bus.cur_sel_o === e.cur) else begin
                mismatched++;
                $error("FAIL %s cur_sel: observed %0d expected %0d", e.tag, bus.cur_sel_o, e.cur);
            end
            compared++;
            assert (bus.wrap_o === e.wrap) else begin
                mismatched++;
                $error("FAIL %s wrap: observed %b expected %b", e.tag, bus.wrap_o, e.wrap);
            end
            compared++;
            assert (bus.out_valid_o === e.valid) else begin
                mismatched++;
                $error("FAIL %s out_valid: observed %b expected %b", e.tag, bus.out_valid_o, e.valid);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        bus.sel_load_i = 1'b0;
        bus.scan_en_i  = 1'b0;
        bus.capture_i  = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        bus.data_i      = 8'b11_10_01_00;
        bus.sel_i       = '0;
        bus.scan_last_i = '0;
        bus.enable_n_i  = '0;
        idle_ctrl();

        #3;
        expect_out("reset", 2'b00, 2'd0, 1'b0, 1'b0); check();
        tick();
        rst = 1'b0;

        // manual load then capture
        bus.sel_i = 2'd2; bus.sel_load_i = 1'b1;
        expect_out("load2", 2'b00, 2'd2, 1'b0, 1'b0); tick(); check();
        bus.sel_load_i = 1'b0; bus.capture_i = 1'b1;
        expect_out("cap2", 2'b10, 2'd2, 1'b0, 1'b1); tick(); check();
        idle_ctrl();

        // scan with scan_last=2 from 0
        bus.sel_i = 2'd0; bus.sel_load_i = 1'b1;
        expect_out("load0", 2'b10, 2'd0, 1'b0, 1'b1); tick(); check();
        idle_ctrl();
        bus.scan_last_i = 2'd2; bus.scan_en_i = 1'b1;
        expect_out("scan2_a", 2'b10, 2'd1, 1'b0, 1'b1); tick(); check();
        expect_out("scan2_b", 2'b10, 2'd2, 1'b0, 1'b1); tick(); check();
        expect_out("scan2_c", 2'b10, 2'd0, 1'b1, 1'b1); tick(); check();
        expect_out("scan2_d", 2'b10, 2'd1, 1'b0, 1'b1); tick(); check();

        // full range: 4-cycle period
        bus.scan_last_i = 2'd3;
        expect_out("scan3_a", 2'b10, 2'd2, 1'b0, 1'b1); tick(); check();
        expect_out("scan3_b", 2'b10, 2'd3, 1'b0, 1'b1); tick(); check();
        expect_out("scan3_c", 2'b10, 2'd0, 1'b1, 1'b1); tick(); check();
        expect_out("scan3_d", 2'b10, 2'd1, 1'b0, 1'b1); tick(); check();
        expect_out("scan3_e", 2'b10, 2'd2, 1'b0, 1'b1); tick(); check();
        expect_out("scan3_f", 2'b10, 2'd3, 1'b0, 1'b1); tick(); check();
        expect_out("scan3_g", 2'b10, 2'd0, 1'b1, 1'b1); tick(); check();

        // out-of-range start: sel 3 with scan_last=1
        idle_ctrl();
        bus.sel_i = 2'd3; bus.sel_load_i = 1'b1;
        expect_out("load3", 2'b10, 2'd3, 1'b0, 1'b1); tick(); check();
        idle_ctrl();
        bus.scan_last_i = 2'd1; bus.scan_en_i = 1'b1;
        expect_out("oor_a", 2'b10, 2'd0, 1'b1, 1'b1); tick(); check();
        expect_out("oor_b", 2'b10, 2'd1, 1'b0, 1'b1); tick(); check();
        expect_out("oor_c", 2'b10, 2'd0, 1'b1, 1'b1); tick(); check();

        // sel_load with sel=0 never pulses wrap
        idle_ctrl();
        bus.sel_i = 2'd0; bus.sel_load_i = 1'b1;
        expect_out("load0_nowrap", 2'b10, 2'd0, 1'b0, 1'b1); tick(); check();

        // simultaneous load, scan and capture
        bus.sel_i = 2'd1;
        expect_out("load1", 2'b10, 2'd1, 1'b0, 1'b1); tick(); check();
        bus.sel_i = 2'd3; bus.sel_load_i = 1'b1; bus.scan_en_i = 1'b1; bus.capture_i = 1'b1;
        expect_out("simul", 2'b01, 2'd3, 1'b0, 1'b1); tick(); check();
        idle_ctrl();

        // capture with scan held: out lags cur_sel by one channel
        bus.scan_last_i = 2'd3; bus.scan_en_i = 1'b1; bus.capture_i = 1'b1;
        expect_out("lag_a", 2'b11, 2'd0, 1'b1, 1'b1); tick(); check();
        expect_out("lag_b", 2'b00, 2'd1, 1'b0, 1'b1); tick(); check();
        expect_out("lag_c", 2'b01, 2'd2, 1'b0, 1'b1); tick(); check();
        idle_ctrl();

        // output enables on data_q=11
        bus.sel_i = 2'd3; bus.sel_load_i = 1'b1;
        expect_out("load3b", 2'b01, 2'd3, 1'b0, 1'b1); tick(); check();
        bus.sel_load_i = 1'b0; bus.capture_i = 1'b1;
        expect_out("cap3", 2'b11, 2'd3, 1'b0, 1'b1); tick(); check();
        idle_ctrl();
        bus.enable_n_i = 2'b01; #1;
        expect_out("en_01", 2'b10, 2'd3, 1'b0, 1'b1); check();
        bus.enable_n_i = 2'b11; #1;
        expect_out("en_11", 2'b00, 2'd3, 1'b0, 1'b1); check();
        bus.enable_n_i = 2'b00; #1;
        expect_out("en_00", 2'b11, 2'd3, 1'b0, 1'b1); check();

        // reset mid-scan
        tick();
        bus.sel_i = 2'd0; bus.sel_load_i = 1'b1;
        expect_out("load0c", 2'b11, 2'd0, 1'b0, 1'b1); tick(); check();
        idle_ctrl();
        bus.scan_last_i = 2'd3; bus.scan_en_i = 1'b1;
        expect_out("pre_a", 2'b11, 2'd1, 1'b0, 1'b1); tick(); check();
        expect_out("pre_b", 2'b11, 2'd2, 1'b0, 1'b1); tick(); check();
        #2 rst = 1'b1;
        #1;
        expect_out("mid_rst", 2'b00, 2'd0, 1'b0, 1'b0); check();
        #1 rst = 1'b0;
        expect_out("post_rst", 2'b00, 2'd1, 1'b0, 1'b0); tick(); check();
        idle_ctrl();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
